adder_driver: RTL and testbench
===============================

// Module: adder_driver
// PURPOSE
//  Initiator side of the stb/ack operand/result protocol used by the float adder.
//  Accepts an operand pair from an upstream valid/ready command port and presents A and B to the adder.
//  Collects output_z and returns it on a valid/ready result port.
//  Sits between the sdc datapath sequencer and the adder; one operation outstanding at a time.
// PARAMETERS
//  WIDTH           32    operand/result width in bits
//  TIMEOUT_CYCLES  1024  cycles allowed per operation before abort (ADDER_DRV_TIMEOUT_EN only)
//  CNT_W           16    width of completed-operation counter
// PORTS
//  clk           in   1      clock, all state on rising edge
//  rst           in   1      asynchronous, active-low reset
//  cmd_a         in   WIDTH  operand A
//  cmd_b         in   WIDTH  operand B
//  cmd_valid     in   1      operand pair offered
//  cmd_ready     out  1      driver accepts pair (IDLE only)
//  input_a       out  WIDTH  to adder, A operand (held registered)
//  input_a_stb   out  1      A strobe
//  input_a_ack   in   1      adder took A
//  input_b       out  WIDTH  to adder, B operand
//  input_b_stb   out  1      B strobe
//  input_b_ack   in   1      adder took B
//  output_z      in   WIDTH  adder result
//  output_z_stb  in   1      result offered
//  output_z_ack  out  1      driver takes result
//  res_z         out  WIDTH  captured result
//  res_valid     out  1      res_z valid
//  res_ready     in   1      downstream takes result
//  busy          out  1      state != IDLE
//  op_count      out  CNT_W  completed operations, wraps at 2^CNT_W
//  err           out  1      timeout abort flag (0 when macro off)
//  err_clr       in   1      clears err, returns to IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1 (IDLE); input_a/b, res_z=0; op_count=0.
//  Transfer rule on every stb/ack pair: a word moves on the clock edge where stb&&ack=1.
//   stb drops the following cycle; data is stable while stb=1.
//  IDLE: cmd_ready=1. On cmd_valid, latch A/B -> SEND; both stbs high the next cycle (latency 1).
//  SEND: each stb is cleared independently on its own handshake. A and B acks may arrive in either order or the same cycle.
//   Both done -> WAIT_Z.
//  WAIT_Z: output_z_ack=1 (combinational from state). On output_z_stb capture res_z, op_count+1 -> HOLD.
//  HOLD: res_valid=1 until res_valid&&res_ready -> IDLE. cmd_ready stays 0 until then, so there is no overlap.
//   Minimum cycles from cmd to res_valid = 3 with zero-wait adder acks.
//  output_z_stb outside WAIT_Z is ignored (ack=0). Stray input_*_ack with stb=0 is ignored.
//  op_count wraps 2^CNT_W-1 -> 0.
//  Reset mid-operation: all stbs/acks drop asynchronously. The adder must be reset on the same rst.
// CONFIGURATION
//  `ADDER_DRV_TIMEOUT_EN defined:
//   Watchdog counts cycles in SEND/WAIT_Z; it reloads on entering SEND.
//   On reaching TIMEOUT_CYCLES: drop all stbs/output_z_ack, err=1 -> state ERR, cmd_ready=0.
//   err_clr in ERR -> IDLE next cycle with err=0. err_clr elsewhere has no effect.
//  Not defined: no counter and no ERR state. err tied 0, err_clr unused, driver waits indefinitely.
// STRUCTURE
//  adder_drv_defs.vh (shared include): state encodings IDLE/SEND/WAIT_Z/HOLD/ERR, default WIDTH.
//  Sub-module adder_drv_watchdog: load/enable/expire counter, instantiated only under the macro.
//  FSM, operand/result registers and op_count live in adder_driver.
// TESTING (bench uses behavioural adder responder with programmable ack/stb delays)
//  1. cmd 0x3F800000+0x3F800000, zero delays -> res_z=0x40000000, res_valid 3 cycles after cmd accept, op_count=1.
//  2. B acked 4 cycles before A -> input_b_stb drops after B ack, input_a_stb held to A ack, result correct.
//  3. res_ready held 0 for 10 cycles -> res_valid/res_z stable, cmd_ready=0, a new cmd_valid is not accepted.
//  4. 2^CNT_W back-to-back ops with CNT_W=4 -> op_count wraps 15 -> 0, no lost results.
//  5. rst low during WAIT_Z -> stbs/output_z_ack/res_valid=0 immediately, cmd_ready=1 after release.
//  6. Macro on, TIMEOUT_CYCLES=8, adder never acks -> err=1 at cycle 8, stbs=0. err_clr -> IDLE, next op completes.

Source files
------------

// File: rtl/adder_driver_pkg.sv
// Shared definitions for the float-adder driver: FSM state encoding and default width.
package adder_driver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT_Z = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } drv_state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/adder_driver_if.sv
// Operand/result stb/ack bus between the driver (master) and the float adder (slave).
interface adder_driver_if
  import adder_driver_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] input_a;
  logic             input_a_stb;
  logic             input_a_ack;
  logic [WIDTH-1:0] input_b;
  logic             input_b_stb;
  logic             input_b_ack;
  logic [WIDTH-1:0] output_z;
  logic             output_z_stb;
  logic             output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );

endinterface

// File: rtl/adder_drv_watchdog.sv
// Per-operation cycle watchdog for adder_driver; only built when ADDER_DRV_TIMEOUT_EN is defined.
`ifdef ADDER_DRV_TIMEOUT_EN
module adder_drv_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count;

  // Restarts at zero when an operation is accepted, then counts every cycle it is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/adder_driver.sv
// Initiator for the float adder stb/ack protocol: one operand pair in, one result out at a time.
// Optional per-operation timeout with ERR state is enabled by defining ADDER_DRV_TIMEOUT_EN.
module adder_driver
  import adder_driver_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  adder_driver_if.master    adder,
  output logic [WIDTH-1:0]  res_z,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic              err,
  input  logic              err_clr
);

  drv_state_t state;
  logic       a_done;
  logic       b_done;

  // An operand counts as delivered once its strobe is down or is being acked this cycle.
  assign a_done = !adder.input_a_stb || adder.input_a_ack;
  assign b_done = !adder.input_b_stb || adder.input_b_ack;

  assign cmd_ready          = (state == IDLE);
  assign busy               = (state != IDLE);
  assign adder.output_z_ack = (state == WAIT_Z);

`ifdef ADDER_DRV_TIMEOUT_EN
  logic expired;

  adder_drv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    ((state == IDLE) && cmd_valid),
    .enable  ((state == SEND) || (state == WAIT_Z)),
    .expired (expired)
  );
`else
  logic unused_cfg;

  assign err        = 1'b0;
  assign unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  // Completion of a handshake takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      adder.input_a     <= '0;
      adder.input_b     <= '0;
      adder.input_a_stb <= 1'b0;
      adder.input_b_stb <= 1'b0;
      res_z             <= '0;
      res_valid         <= 1'b0;
      op_count          <= '0;
`ifdef ADDER_DRV_TIMEOUT_EN
      err               <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            adder.input_a     <= cmd_a;
            adder.input_b     <= cmd_b;
            adder.input_a_stb <= 1'b1;
            adder.input_b_stb <= 1'b1;
            state             <= SEND;
          end
        end
        SEND: begin
          if (adder.input_a_ack) adder.input_a_stb <= 1'b0;
          if (adder.input_b_ack) adder.input_b_stb <= 1'b0;
          if (a_done && b_done) begin
            state <= WAIT_Z;
          end
`ifdef ADDER_DRV_TIMEOUT_EN
          else if (expired) begin
            adder.input_a_stb <= 1'b0;
            adder.input_b_stb <= 1'b0;
            err               <= 1'b1;
            state             <= ERR;
          end
`endif
        end
        WAIT_Z: begin
          if (adder.output_z_stb) begin
            res_z     <= adder.output_z;
            res_valid <= 1'b1;
            op_count  <= op_count + CNT_W'(1);
            state     <= HOLD;
          end
`ifdef ADDER_DRV_TIMEOUT_EN
          else if (expired) begin
            err   <= 1'b1;
            state <= ERR;
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef ADDER_DRV_TIMEOUT_EN
        ERR: begin
          if (err_clr) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_driver.sv
// Self-checking bench for adder_driver with a behavioural adder responder (programmable delays).
// Define ADDER_DRV_TIMEOUT_EN for both bench and RTL to exercise the timeout/ERR path.
module tb_adder_driver;

  localparam int W   = 32;
  localparam int CNT = 4;
  localparam int TO  = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           a_dly;
    int           b_dly;
    int           z_dly;
    logic [W-1:0] z;
    int           lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   cmd_a = '0;
  logic [W-1:0]   cmd_b = '0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [W-1:0]   res_z;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic           busy;
  logic [CNT-1:0] op_count;
  logic           err;
  logic           err_clr = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [CNT-1:0] exp_count = '0;

  // Responder controls and state
  int           a_dly = 0;
  int           b_dly = 0;
  int           z_dly = 0;
  int           a_cnt;
  int           b_cnt;
  int           z_cnt;
  logic         got_a;
  logic         got_b;
  logic [W-1:0] a_val;
  logic [W-1:0] b_val;
  logic         stray_ack = 1'b0;
  logic         stray_z = 1'b0;
  logic [W-1:0] stray_val = '0;

  always #5 clk = ~clk;

  adder_driver_if #(.WIDTH(W)) bus ();

  adder_driver #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .adder     (bus),
    .res_z     (res_z),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .op_count  (op_count),
    .err       (err),
    .err_clr   (err_clr)
  );

  // Equal normal operands are doubled exactly (exponent+1); anything else yields the integer sum.
  function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b && a[30:23] != 8'h00 && a[30:23] < 8'hFE)
      return {a[31], a[30:23] + 8'd1, a[22:0]};
    return a + b;
  endfunction

  assign bus.input_a_ack  = (bus.input_a_stb && !got_a && a_cnt >= a_dly) || stray_ack;
  assign bus.input_b_ack  = (bus.input_b_stb && !got_b && b_cnt >= b_dly) || stray_ack;
  assign bus.output_z_stb = (got_a && got_b && z_cnt >= z_dly) || stray_z;
  assign bus.output_z     = stray_z ? stray_val : model_add(a_val, b_val);

  // Behavioural adder: takes each operand after its delay, then offers the sum after z_dly.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
      got_a <= 1'b0; got_b <= 1'b0;
      a_val <= '0; b_val <= '0;
    end else begin
      if (bus.input_a_stb && !got_a) begin
        if (bus.input_a_ack) begin got_a <= 1'b1; a_val <= bus.input_a; end
        else a_cnt <= a_cnt + 1;
      end
      if (bus.input_b_stb && !got_b) begin
        if (bus.input_b_ack) begin got_b <= 1'b1; b_val <= bus.input_b; end
        else b_cnt <= b_cnt + 1;
      end
      if (got_a && got_b && z_cnt < z_dly) z_cnt <= z_cnt + 1;
      if (bus.output_z_stb && bus.output_z_ack && !stray_z) begin
        got_a <= 1'b0; got_b <= 1'b0;
        a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Offers a pair at a negedge and returns at the negedge one cycle after acceptance.
  task automatic start_cmd(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checkOutput("cmd_ready_before_accept", W'(cmd_ready), W'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output int cycles);
    cycles = start;
    while (!res_valid && cycles < 300) begin @(negedge clk); cycles++; end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    int lat;
    a_dly = v.a_dly; b_dly = v.b_dly; z_dly = v.z_dly; res_ready = 1'b0;
    start_cmd(v.a, v.b);
    wait_result(1, lat);
    checkOutput({name, "_latency"}, W'(lat), W'(v.lat));
    checkOutput({name, "_res_z"}, res_z, v.z);
    exp_count = exp_count + 1'b1;
    checkOutput({name, "_op_count"}, W'(op_count), W'(exp_count));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput({name, "_idle_after"}, W'({cmd_ready, res_valid}), W'(2'b10));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    vec_t vecs[5];
    vec_t w;
    int lat;
    vecs[0] = '{32'h3F800000, 32'h3F800000, 0, 0, 0, 32'h40000000, 3};
    vecs[1] = '{32'h40000000, 32'h40000000, 1, 0, 0, 32'h40800000, 4};
    vecs[2] = '{32'h12345678, 32'h00000001, 0, 2, 1, 32'h12345679, 6};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 3, 3, 0, 32'h00000000, 6};
    vecs[4] = '{32'h3F800000, 32'h40000000, 0, 0, 2, 32'h7F800000, 5};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_ready", W'(cmd_ready), W'(1));
    checkOutput("rst_flags", W'({busy, bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, res_valid, err}), W'(0));
    checkOutput("rst_input_a", bus.input_a, '0);
    checkOutput("rst_input_b", bus.input_b, '0);
    checkOutput("rst_res_z", res_z, '0);
    checkOutput("rst_op_count", W'(op_count), W'(0));
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) applyStimulus($sformatf("vec%0d", i), vecs[i]);

    // B acked four cycles before A
    a_dly = 4; b_dly = 0; z_dly = 0;
    start_cmd(32'h40400000, 32'h40400000);
    checkOutput("order_both_stb", W'({bus.input_a_stb, bus.input_b_stb}), W'(2'b11));
    @(negedge clk);
    checkOutput("order_b_dropped", W'({bus.input_a_stb, bus.input_b_stb}), W'(2'b10));
    repeat (3) begin
      @(negedge clk);
      checkOutput("order_a_held", W'({bus.input_a_stb, bus.input_b_stb}), W'(2'b10));
      checkOutput("order_a_stable", bus.input_a, 32'h40400000);
    end
    @(negedge clk);
    checkOutput("order_a_dropped", W'({bus.input_a_stb, bus.output_z_ack}), W'(2'b01));
    wait_result(6, lat);
    checkOutput("order_latency", W'(lat), W'(7));
    checkOutput("order_res_z", res_z, 32'h40C00000);
    exp_count = exp_count + 1'b1;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

    // Result held while downstream stalls; new commands and stray acks/strobes ignored
    a_dly = 0; b_dly = 0; z_dly = 0;
    start_cmd(32'h40000000, 32'h40000000);
    wait_result(1, lat);
    exp_count = exp_count + 1'b1;
    cmd_a = 32'h11111111; cmd_b = 32'h22222222; cmd_valid = 1'b1;
    stray_ack = 1'b1; stray_z = 1'b1; stray_val = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d_res_z", i), res_z, 32'h40800000);
      checkOutput($sformatf("hold%0d_flags", i),
                  W'({res_valid, cmd_ready, bus.input_a_stb, bus.input_b_stb, bus.output_z_ack}), W'(5'b10000));
    end
    cmd_valid = 1'b0; stray_ack = 1'b0; stray_z = 1'b0;
    checkOutput("hold_op_count", W'(op_count), W'(exp_count));
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    checkOutput("hold_released", W'({cmd_ready, res_valid}), W'(2'b10));

    // Sixteen back-to-back operations wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      w = '{32'h100 + i, 32'h5, 0, 0, 0, 32'h105 + i, 3};
      applyStimulus($sformatf("wrap%0d", i), w);
    end

    // Asynchronous reset while waiting for the result
    z_dly = 5;
    start_cmd(32'h3F800000, 32'h3F800000);
    @(negedge clk);
    checkOutput("rstmid_in_wait_z", W'(bus.output_z_ack), W'(1));
    #2 rst = 1'b0;
    #1;
    checkOutput("rstmid_flags", W'({bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, res_valid, busy}), W'(0));
    checkOutput("rstmid_op_count", W'(op_count), W'(0));
    exp_count = '0;
    z_dly = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_cmd_ready", W'(cmd_ready), W'(1));
    applyStimulus("after_rst", '{32'h00000010, 32'h00000020, 0, 0, 0, 32'h00000030, 3});

`ifdef ADDER_DRV_TIMEOUT_EN
    // Adder never acks: abort after TIMEOUT_CYCLES, then recover via err_clr
    a_dly = 1000; b_dly = 1000;
    start_cmd(32'h3F800000, 32'h3F800000);
    repeat (7) @(negedge clk);
    checkOutput("to_before", W'({err, bus.input_a_stb, bus.input_b_stb}), W'(3'b011));
    @(negedge clk);
    checkOutput("to_err", W'({err, bus.input_a_stb, bus.input_b_stb, bus.output_z_ack, cmd_ready, busy}),
                W'(6'b100001));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("to_cleared", W'({err, cmd_ready}), W'(2'b01));
    checkOutput("to_op_count", W'(op_count), W'(exp_count));
    applyStimulus("after_to", '{32'h3F800000, 32'h3F800000, 0, 0, 0, 32'h40000000, 3});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
